// File: rtl/spi_slave_core.sv
// SPI responder core: modes 0-3, MSB first, one word per D_WIDTH SCLK cycles.
// SCLK, SS_N and MOSI are asynchronous pins oversampled in the clock domain.
// Received words go to the local bus; a CPU-loaded holding register feeds the reply.

module spi_slave_core #(
    parameter int D_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               tx_load,
    output logic               tx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               busy,
    output logic               underrun,
    output logic               frame_err
);

    localparam int CW = $clog2(D_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(D_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;

    logic [D_WIDTH-1:0] holding;
    logic [D_WIDTH-1:0] shift_tx;
    logic [D_WIDTH-1:0] shift_rx;
    logic [D_WIDTH-1:0] load_word;
    logic [D_WIDTH-1:0] rx_next;
    logic [CW-1:0]      bit_count;
    logic               present_msb;

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic ss_fall, word_done, load_shift;

    // Two-flop synchronisers for the pins plus a history flop for edge detection.
    // Resetting ss to 0 means a select held low through reset is not mistaken for a new frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            ss_meta   <= 1'b0;
            ss_sync   <= 1'b0;
            ss_prev   <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= ss_n;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // Edge classification, word-complete detection and the word the shifter will load next.
    always_comb begin
        lead_edge   = (sclk_sync != sclk_prev) && (sclk_prev == cpol);
        trail_edge  = (sclk_sync != sclk_prev) && (sclk_sync == cpol);
        sample_edge = cpha ? trail_edge : lead_edge;
        shift_edge  = cpha ? lead_edge : trail_edge;
        ss_fall     = ss_prev && !ss_sync;
        word_done   = (state == ACTIVE) && !ss_sync && sample_edge && (bit_count == LAST_BIT);
        load_shift  = ((state == IDLE) && ss_fall) || word_done;
        load_word   = tx_ready ? '0 : holding;
        rx_next     = D_WIDTH'({shift_rx, mosi_sync});
    end

    // Holding register: a CPU write always wins over a same-cycle transfer into the shifter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            holding  <= '0;
            tx_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= load_shift && tx_ready;
            if (tx_load) begin
                holding  <= tx_data;
                tx_ready <= 1'b0;
            end else if (load_shift) begin
                tx_ready <= 1'b1;
            end
        end
    end

    // Frame FSM: tracks select, samples MOSI, drives MISO and reports words and aborts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            shift_tx    <= '0;
            shift_rx    <= '0;
            bit_count   <= '0;
            present_msb <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    miso_oe <= 1'b0;
                    busy    <= 1'b0;
                    if (ss_fall) begin
                        shift_tx  <= load_word;
                        bit_count <= '0;
                        miso_oe   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ACTIVE;
                        if (!cpha) begin
                            miso        <= load_word[D_WIDTH-1];
                            present_msb <= 1'b0;
                        end else begin
                            miso        <= 1'b0;
                            present_msb <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_sync) begin
                        state     <= IDLE;
                        miso_oe   <= 1'b0;
                        miso      <= 1'b0;
                        busy      <= 1'b0;
                        frame_err <= (bit_count != '0);
                        bit_count <= '0;
                    end else begin
                        if (sample_edge) begin
                            shift_rx <= rx_next;
                            if (bit_count == LAST_BIT) begin
                                rx_data     <= rx_next;
                                rx_valid    <= 1'b1;
                                bit_count   <= '0;
                                shift_tx    <= load_word;
                                present_msb <= 1'b1;
                            end else begin
                                bit_count <= bit_count + 1'b1;
                            end
                        end
                        if (shift_edge) begin
                            if (present_msb) begin
                                miso        <= shift_tx[D_WIDTH-1];
                                present_msb <= 1'b0;
                            end else begin
                                shift_tx <= shift_tx << 1;
                                miso     <= shift_tx[D_WIDTH-2];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: acts as an SPI master, checks the slave
// against a word-level model (rx words, reply bits, underrun/frame_err counts).

module tb_spi_slave_core;

    localparam int DW   = 8;
    localparam int HALF = 6;

    logic          clock;
    logic          reset_n;
    logic          cpol, cpha, sclk, ss_n, mosi;
    logic          miso, miso_oe;
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy, underrun, frame_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] rx_log [256];
    int rx_total = 0;
    int underrun_total = 0;
    int frame_err_total = 0;

    typedef struct {
        logic [1:0]  mode;
        int          n_words;
        logic [23:0] tx;
        logic [23:0] rx;
        bit          preload;
    } vec_t;

    vec_t vecs [7];

    spi_slave_core #(.D_WIDTH(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cpol      (cpol),
        .cpha      (cpha),
        .sclk      (sclk),
        .ss_n      (ss_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log every pulse output on the falling edge, away from the DUT's active edge.
    always @(negedge clock) begin
        if (rx_valid) begin
            rx_log[rx_total % 256] = rx_data;
            rx_total = rx_total + 1;
        end
        if (underrun) underrun_total = underrun_total + 1;
        if (frame_err) frame_err_total = frame_err_total + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic pulseLoad(input logic [DW-1:0] value);
        tx_data = value;
        tx_load = 1'b1;
        @(negedge clock);
        tx_load = 1'b0;
    endtask

    task automatic waitHalf(input bit do_load, input logic [DW-1:0] value);
        if (do_load) begin
            pulseLoad(value);
            repeat (HALF - 1) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
    endtask

    // Master side of one frame. tx words are right-aligned, word 0 most significant.
    task automatic applyStimulus(input logic [1:0] mode, input int n_bits, input logic [31:0] mosi_bits,
                                 input logic [23:0] tx_words, input bit preload,
                                 output logic [31:0] miso_bits, output int provided,
                                 output logic busy_mid, output logic oe_mid);
        int n_words;
        int w;
        bit do_load;
        logic [DW-1:0] next_word;
        n_words   = (n_bits + DW - 1) / DW;
        provided  = 0;
        miso_bits = '0;
        busy_mid  = 1'b0;
        oe_mid    = 1'b0;
        cpol = mode[1];
        cpha = mode[0];
        sclk = mode[1];
        mosi = 1'b0;
        if (preload) begin
            pulseLoad(tx_words[(n_words-1)*DW +: DW]);
            provided++;
        end
        repeat (4) @(negedge clock);
        ss_n = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < n_bits; i++) begin
            w = i / DW;
            do_load = ((i % DW) == 1) && (w + 1 < n_words);
            next_word = do_load ? tx_words[(n_words-2-w)*DW +: DW] : '0;
            if (do_load) provided++;
            if (!cpha) begin
                mosi = mosi_bits[n_bits-1-i];
                waitHalf(do_load, next_word);
                miso_bits[n_bits-1-i] = miso;
                sclk = ~cpol;
                waitHalf(1'b0, '0);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = mosi_bits[n_bits-1-i];
                waitHalf(do_load, next_word);
                sclk = cpol;
                miso_bits[n_bits-1-i] = miso;
                waitHalf(1'b0, '0);
            end
            if (i == 0) begin
                busy_mid = busy;
                oe_mid   = miso_oe;
            end
        end
        waitHalf(1'b0, '0);
        ss_n = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    // Run a whole-word frame and compare against the word-level model.
    task automatic runFrame(input string name, input logic [1:0] mode, input int n_words,
                            input logic [23:0] tx, input logic [23:0] rx, input bit preload);
        logic [31:0] miso_bits, exp_miso;
        logic [7:0]  word;
        logic        busy_mid, oe_mid;
        int provided, rx_base, ur_base, fe_base, sh;
        rx_base = rx_total;
        ur_base = underrun_total;
        fe_base = frame_err_total;
        applyStimulus(mode, n_words * DW, {8'h00, rx}, tx, preload, miso_bits, provided, busy_mid, oe_mid);
        exp_miso = '0;
        for (int k = 0; k < n_words; k++) begin
            sh = (n_words - 1 - k) * DW;
            word = (preload || k > 0) ? tx[sh +: DW] : 8'h00;
            exp_miso = exp_miso | (32'(word) << sh);
        end
        checkOutput({name, " miso"}, miso_bits, exp_miso);
        checkOutput({name, " rx_count"}, 32'(rx_total - rx_base), 32'(n_words));
        for (int k = 0; k < n_words; k++)
            checkOutput($sformatf("%s rx_word%0d", name, k), 32'(rx_log[(rx_base + k) % 256]),
                        32'(rx[(n_words-1-k)*DW +: DW]));
        checkOutput({name, " underrun"}, 32'(underrun_total - ur_base), 32'(1 + n_words - provided));
        checkOutput({name, " frame_err"}, 32'(frame_err_total - fe_base), 32'd0);
        checkOutput({name, " busy/oe in frame"}, {30'd0, busy_mid, oe_mid}, 32'd3);
        checkOutput({name, " idle outputs"}, {28'd0, busy, miso_oe, miso, tx_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] miso_bits;
        logic        busy_mid, oe_mid;
        logic [7:0]  prev_rx;
        int provided, rx_base, ur_base, fe_base;

        reset_n = 1'b0;
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_load = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset state",
                    {miso, miso_oe, tx_ready, rx_valid, busy, underrun, frame_err, rx_data},
                    {7'b0010000, 8'h00});
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        vecs[0] = '{2'd0, 1, 24'h0000A5, 24'h00003C, 1'b1};
        vecs[1] = '{2'd1, 1, 24'h000081, 24'h00007E, 1'b1};
        vecs[2] = '{2'd2, 1, 24'h000081, 24'h00007E, 1'b1};
        vecs[3] = '{2'd3, 1, 24'h000081, 24'h00007E, 1'b1};
        vecs[4] = '{2'd0, 2, 24'h005AC3, 24'h001234, 1'b1};
        vecs[5] = '{2'd3, 2, 24'h00F00F, 24'h001234, 1'b1};
        vecs[6] = '{2'd0, 1, 24'h0000FF, 24'h000096, 1'b0};
        for (int v = 0; v < 7; v++)
            runFrame($sformatf("vec%0d", v), vecs[v].mode, vecs[v].n_words, vecs[v].tx, vecs[v].rx, vecs[v].preload);

        // Overwrite of a full holding register: the second write must be the one sent.
        pulseLoad(8'h11);
        checkOutput("tx_ready after load", {31'd0, tx_ready}, 32'd0);
        runFrame("overwrite", 2'd1, 1, 24'h000022, 24'h0000C9, 1'b1);

        // Select released after 3 bits: abort, rx_data untouched, next frame clean.
        prev_rx = rx_data;
        rx_base = rx_total;
        ur_base = underrun_total;
        fe_base = frame_err_total;
        applyStimulus(2'd0, 3, 32'b101, 24'h0000E7, 1'b1, miso_bits, provided, busy_mid, oe_mid);
        checkOutput("abort frame_err", 32'(frame_err_total - fe_base), 32'd1);
        checkOutput("abort rx_count", 32'(rx_total - rx_base), 32'd0);
        checkOutput("abort rx_data", 32'(rx_data), 32'(prev_rx));
        checkOutput("abort miso", miso_bits, 32'b111);
        checkOutput("abort underrun", 32'(underrun_total - ur_base), 32'd0);
        checkOutput("abort tx_ready", {31'd0, tx_ready}, 32'd1);
        runFrame("after abort", 2'd0, 1, 24'h00004B, 24'h0000D2, 1'b1);

        // Reset asserted mid-word; select stays low through reset release.
        pulseLoad(8'h81);
        cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
        repeat (4) @(negedge clock);
        ss_n = 1'b0;
        repeat (8) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            mosi = i[0];
            repeat (HALF) @(negedge clock);
            sclk = 1'b1;
            repeat (HALF) @(negedge clock);
            sclk = 1'b0;
        end
        checkOutput("pre-reset busy/oe", {30'd0, busy, miso_oe}, 32'd3);
        reset_n = 1'b0;
        #1;
        checkOutput("mid-frame reset",
                    {miso, miso_oe, tx_ready, rx_valid, busy, underrun, frame_err, rx_data},
                    {7'b0010000, 8'h00});
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        checkOutput("no frame without fresh select", {30'd0, busy, miso_oe}, 32'd0);
        ss_n = 1'b1;
        repeat (4) @(negedge clock);
        runFrame("after reset", 2'd2, 1, 24'h00005C, 24'h0000A3, 1'b1);

        // Randomised frames against the word-level model.
        for (int t = 0; t < 16; t++) begin
            logic [1:0]  r_mode;
            int          r_words;
            logic [23:0] r_tx, r_rx, r_mask;
            bit          r_pre;
            r_mode  = 2'($urandom_range(0, 3));
            r_words = $urandom_range(1, 3);
            r_mask  = 24'((32'd1 << (r_words * DW)) - 1);
            r_tx    = 24'($urandom) & r_mask;
            r_rx    = 24'($urandom) & r_mask;
            r_pre   = 1'($urandom_range(0, 1));
            runFrame($sformatf("rand%0d", t), r_mode, r_words, r_tx, r_rx, r_pre);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
